// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving an 8:1 mux select/enable with break-before-make and hold limiting.
// Define FIXED_PRI0_EN to make channel 0 a fixed highest-priority requester that can force releases.
module mux_select_arbiter #(
    parameter int MAX_HOLD      = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int DELAY_RISE    = 0,
    parameter int DELAY_FALL    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] S,
    output logic       Output_bar,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;

    localparam logic [3:0] MAX_HOLD_C  = 4'(MAX_HOLD);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    // Output delays only matter for annotated timing simulation; here they are range-checked only.
    if (MAX_HOLD < 1 || MAX_HOLD > 15 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
        DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
        $error("mux_select_arbiter: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] s_q, s_d;
    logic       oe_bar_q, oe_bar_d;
    logic [2:0] last_q, last_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] settle_cnt_q, settle_cnt_d;

    logic [2:0] winner;
    logic [2:0] scan_idx;
    logic       found;
    logic       others_pending;
    logic       release_now;

    always_comb begin
        winner   = last_q;
        scan_idx = last_q;
        found    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            scan_idx = last_q + 3'(k);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
`ifdef FIXED_PRI0_EN
        if (req[0]) begin
            winner = 3'd0;
        end
`endif
    end

    // While a grant is held, S always equals the owning channel.
    assign others_pending = |(req & ~(8'd1 << s_q));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        s_d          = s_q;
        oe_bar_d     = oe_bar_q;
        last_d       = last_q;
        hold_cnt_d   = hold_cnt_q;
        settle_cnt_d = settle_cnt_q;
        release_now  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    s_d          = winner;
                    settle_cnt_d = SETTLE_INIT;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (!req[s_q]) begin
                    state_d = IDLE;
                end else if (settle_cnt_q == 4'd0) begin
                    grant_d    = 8'd1 << s_q;
                    oe_bar_d   = 1'b0;
                    hold_cnt_d = 4'd1;
                    state_d    = GRANT;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            GRANT: begin
`ifdef FIXED_PRI0_EN
                release_now = !req[s_q] ||
                              ((s_q != 3'd0) &&
                               (req[0] || ((hold_cnt_q == MAX_HOLD_C) && others_pending)));
`else
                release_now = !req[s_q] || ((hold_cnt_q == MAX_HOLD_C) && others_pending);
`endif
                if (release_now) begin
                    grant_d  = 8'd0;
                    oe_bar_d = 1'b1;
                    last_d   = s_q;
                    state_d  = IDLE;
                end else if (hold_cnt_q != MAX_HOLD_C) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 8'd0;
            s_q          <= 3'd0;
            oe_bar_q     <= 1'b1;
            last_q       <= 3'd7;
            hold_cnt_q   <= 4'd0;
            settle_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            s_q          <= s_d;
            oe_bar_q     <= oe_bar_d;
            last_q       <= last_d;
            hold_cnt_q   <= hold_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign grant      = grant_q;
    assign S          = s_q;
    assign Output_bar = oe_bar_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Testbench for mux_select_arbiter: directed request patterns checked against a cycle-count model.
// Honours FIXED_PRI0_EN the same way as the design when it is defined at compile time.
module tb_mux_select_arbiter;
    localparam int MAX_HOLD      = 4;
    localparam int SETTLE_CYCLES = 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req   = 8'h00;
    logic [7:0] grant;
    logic [2:0] S;
    logic       Output_bar;
    logic       busy;

    int total = 0;
    int bad   = 0;

    mux_select_arbiter #(
        .MAX_HOLD     (MAX_HOLD),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .DELAY_RISE   (0),
        .DELAY_FALL   (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .S         (S),
        .Output_bar(Output_bar),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model: who owns the mux, who is waiting to settle, and the edge numbers at which things happened.
    int m_cyc   = 0;
    int m_owner = -1;
    int m_cand  = -1;
    int m_sel   = 0;
    int m_last  = 7;
    int m_start = 0;
    int m_ready = 0;

    initial begin
        forever begin
            logic [7:0] others;
            logic       rel;
            int         w;
            @(posedge clk);
            m_cyc++;
            if (reset) begin
                m_owner = -1;
                m_cand  = -1;
                m_sel   = 0;
                m_last  = 7;
            end else if (m_owner >= 0) begin
                others = req & ~(8'(1) << m_owner);
`ifdef FIXED_PRI0_EN
                rel = !req[m_owner] || (m_owner != 0 &&
                      (req[0] || ((m_cyc - m_start) >= MAX_HOLD && others != 0)));
`else
                rel = !req[m_owner] || ((m_cyc - m_start) >= MAX_HOLD && others != 0);
`endif
                if (rel) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (m_cand >= 0) begin
                if (!req[m_cand]) begin
                    m_cand = -1;
                end else if (m_cyc == m_ready) begin
                    m_owner = m_cand;
                    m_cand  = -1;
                    m_start = m_cyc;
                end
            end else if (req != 8'h00) begin
                w = -1;
                for (int k = 1; k <= 8; k++) begin
                    if (w < 0 && req[(m_last + k) % 8]) w = (m_last + k) % 8;
                end
`ifdef FIXED_PRI0_EN
                if (req[0]) w = 0;
`endif
                m_cand  = w;
                m_sel   = w;
                m_ready = m_cyc + SETTLE_CYCLES;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] eg, input logic [2:0] es,
                               input logic eo, input logic eb);
        total++;
        if (grant !== eg || S !== es || Output_bar !== eo || busy !== eb) begin
            bad++;
            $display("[TB] FAIL %s t=%0t: got grant=%h S=%0d Output_bar=%b busy=%b, want grant=%h S=%0d Output_bar=%b busy=%b",
                     tag, $time, grant, S, Output_bar, busy, eg, es, eo, eb);
        end
    endtask

    // Per-cycle comparison against the model, plus the structural invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (m_cyc > 0) begin
                checkOutput("model", (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00, 3'(m_sel),
                            (m_owner < 0), (m_owner >= 0 || m_cand >= 0));
                total++;
                if ((grant != 8'h00 && (Output_bar !== 1'b0 || grant !== (8'(1) << S))) ||
                    (Output_bar === 1'b1 && grant != 8'h00)) begin
                    bad++;
                    $display("[TB] FAIL invariant t=%0t: grant=%h S=%0d Output_bar=%b", $time, grant, S, Output_bar);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] r, input logic rst, input int n);
        req   = r;
        reset = rst;
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] patterns [7] = '{8'h81, 8'h5A, 8'h01, 8'hC3, 8'h10, 8'hFF, 8'h00};

    initial begin
        applyStimulus(8'hFF, 1'b1, 2);  checkOutput("reset",            8'h00, 3'd0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1);  checkOutput("rst_rel_settle",   8'h00, 3'd0, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1);  checkOutput("first_grant_ch0",  8'h01, 3'd0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1);  checkOutput("release_ch0",      8'h00, 3'd0, 1'b1, 1'b0);

        applyStimulus(8'h08, 1'b0, 1);  checkOutput("single_settle",    8'h00, 3'd3, 1'b1, 1'b1);
        applyStimulus(8'h08, 1'b0, 1);  checkOutput("single_grant",     8'h08, 3'd3, 1'b0, 1'b1);
        applyStimulus(8'h08, 1'b0, 8);  checkOutput("single_lone_hold", 8'h08, 3'd3, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1);  checkOutput("single_release",   8'h00, 3'd3, 1'b1, 1'b0);

        applyStimulus(8'h22, 1'b0, 1);  checkOutput("cont_settle5",     8'h00, 3'd5, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b0, 1);  checkOutput("cont_grant5",      8'h20, 3'd5, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 3);  checkOutput("cont_grant5_4th",  8'h20, 3'd5, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 1);  checkOutput("cont_gap1",        8'h00, 3'd5, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b0, 1);  checkOutput("cont_gap2",        8'h00, 3'd1, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b0, 1);  checkOutput("cont_grant1",      8'h02, 3'd1, 1'b0, 1'b1);
        applyStimulus(8'h22, 1'b0, 20);
        applyStimulus(8'h00, 1'b0, 2);  checkOutput("cont_idle",        8'h00, 3'd5, 1'b1, 1'b0);

        applyStimulus(8'h80, 1'b0, 1);  checkOutput("wrap_settle7",     8'h00, 3'd7, 1'b1, 1'b1);
        applyStimulus(8'h80, 1'b0, 1);  checkOutput("wrap_grant7",      8'h80, 3'd7, 1'b0, 1'b1);
        applyStimulus(8'h41, 1'b0, 1);  checkOutput("wrap_release7",    8'h00, 3'd7, 1'b1, 1'b0);
        applyStimulus(8'h41, 1'b0, 1);  checkOutput("wrap_pick0",       8'h00, 3'd0, 1'b1, 1'b1);
        applyStimulus(8'h41, 1'b0, 1);  checkOutput("wrap_grant0",      8'h01, 3'd0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1);  checkOutput("wrap_idle",        8'h00, 3'd0, 1'b1, 1'b0);

        applyStimulus(8'h24, 1'b0, 1);  checkOutput("abort_settle2",    8'h00, 3'd2, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1);  checkOutput("abort_idle",       8'h00, 3'd2, 1'b1, 1'b0);
        applyStimulus(8'h0A, 1'b0, 1);  checkOutput("abort_repick1",    8'h00, 3'd1, 1'b1, 1'b1);
        applyStimulus(8'h0A, 1'b0, 1);  checkOutput("abort_grant1",     8'h02, 3'd1, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1);

        applyStimulus(8'h10, 1'b0, 1);  checkOutput("mid_settle4",      8'h00, 3'd4, 1'b1, 1'b1);
        applyStimulus(8'h10, 1'b0, 1);  checkOutput("mid_grant4",       8'h10, 3'd4, 1'b0, 1'b1);
        applyStimulus(8'h10, 1'b1, 1);  checkOutput("mid_reset",        8'h00, 3'd0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1);  checkOutput("mid_reset_ptr",    8'h00, 3'd0, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1);  checkOutput("mid_reset_grant0", 8'h01, 3'd0, 1'b0, 1'b1);

`ifdef FIXED_PRI0_EN
        applyStimulus(8'hFF, 1'b0, 20); checkOutput("pri0_no_preempt",  8'h01, 3'd0, 1'b0, 1'b1);
        applyStimulus(8'h08, 1'b0, 1);  checkOutput("pri0_drop",        8'h00, 3'd0, 1'b1, 1'b0);
        applyStimulus(8'h08, 1'b0, 1);  checkOutput("pri0_settle3",     8'h00, 3'd3, 1'b1, 1'b1);
        applyStimulus(8'h08, 1'b0, 1);  checkOutput("pri0_grant3",      8'h08, 3'd3, 1'b0, 1'b1);
        applyStimulus(8'h09, 1'b0, 1);  checkOutput("pri0_force_rel",   8'h00, 3'd3, 1'b1, 1'b0);
        applyStimulus(8'h09, 1'b0, 1);  checkOutput("pri0_pick0",       8'h00, 3'd0, 1'b1, 1'b1);
        applyStimulus(8'h09, 1'b0, 1);  checkOutput("pri0_grant0",      8'h01, 3'd0, 1'b0, 1'b1);
`else
        applyStimulus(8'hFF, 1'b0, 3);  checkOutput("rr_hold0_4th",     8'h01, 3'd0, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1);  checkOutput("rr_preempt0",      8'h00, 3'd0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1);  checkOutput("rr_settle1",       8'h00, 3'd1, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b0, 1);  checkOutput("rr_grant1",        8'h02, 3'd1, 1'b0, 1'b1);
`endif

        foreach (patterns[i]) applyStimulus(patterns[i], 1'b0, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_select_arbiter.md
Name: mux_select_arbiter

Overview:
Round-robin arbiter that shares one 8-input multiplexer (8 inputs, 3-bit select S, active-low output enable Output_bar) among eight requesters. It drives the mux select and enable. It enforces break-before-make: the mux output is disabled while the select changes. It also limits how long one requester may hold the mux while others are waiting. The block sits beside the mux in the datapath; requester i owns mux input I[i].

Parameters:
MAX_HOLD, 4, maximum granted cycles while another request is pending; range 1..15.
SETTLE_CYCLES, 1, cycles the new select is held with the output disabled before grant; range 1..15.
DELAY_RISE, 0, rise delay on S/Output_bar/grant outputs (simulation only).
DELAY_FALL, 0, fall delay on S/Output_bar/grant outputs (simulation only).

Ports:
clk  input  1  single clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
req  input  8  request lines, one per mux input; level-sensitive; held high while access is wanted.
grant  output  8  one-hot grant; at most one bit set.
S  output  3  mux select.
Output_bar  output  1  mux enable, active low; 1 = mux disabled.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (sampled at clk edge, dominates everything):
  - state=IDLE, grant=0, S=0, Output_bar=1, busy=0.
  - Internal last pointer=7, so ch0 is searched first.
  - hold_cnt=0, settle_cnt=0.
- Winner selection: first asserted req[i] found scanning upward from (last+1) mod 8, wrapping 7->0.
- States: IDLE, SETTLE, GRANT.
- IDLE, at an edge where any req is high:
  - Winner w is captured.
  - S<=w, Output_bar stays 1, settle_cnt<=SETTLE_CYCLES-1, go SETTLE.
- IDLE with no req: all outputs hold; S keeps its last value.
- SETTLE:
  - If req[w] is low at an edge: return to IDLE; last is unchanged; no grant is issued.
  - Else, if settle_cnt==0: grant[w]<=1, Output_bar<=0, hold_cnt<=1, go GRANT.
  - Else: settle_cnt decrements.
- Timing: req[w] first sampled at edge N -> S=w after edge N -> grant/Output_bar=0 after edge N+SETTLE_CYCLES.
- GRANT, checked at each edge in priority order:
  - (a) req[w] low: release.
  - (b) hold_cnt==MAX_HOLD and some other req high: release (preemption).
  - (c) otherwise: hold_cnt increments, saturating at MAX_HOLD.
- Release: grant<=0, Output_bar<=1, last<=w, go IDLE. S is unchanged during release.
- Gaps: between consecutive grants Output_bar is high for exactly 1+SETTLE_CYCLES cycles. Grant never moves directly between channels.
- A lone requester keeps the grant indefinitely (hold_cnt saturates). Preemption fires on the first edge at which both hold_cnt==MAX_HOLD and another request are present.
- Requests from other channels that arrive during SETTLE or GRANT do not disturb w.
- Invariants:
  - grant!=0 implies Output_bar==0 and grant==(1<<S).
  - Output_bar==1 implies grant==0.

Optional Feature:
FIXED_PRI0_EN
- Defined:
  - ch0 is fixed highest priority; in IDLE req[0] wins regardless of last.
  - In GRANT with w!=0, req[0] high forces release at that edge, ignoring hold_cnt.
  - A ch0 grant is never preempted by the MAX_HOLD rule; it releases only when req[0] drops.
  - SETTLE is not aborted by req[0]; ch0 takes the next arbitration.
  - last is still updated, so the rotation among ch1..7 is preserved.
- Undefined: pure round-robin as above; ch0 has no special treatment.

Test Plan:
- Reset check: assert reset 2 cycles while req=8'hFF -> grant=0, S=0, Output_bar=1, busy=0. After release the first grant goes to ch0 at edge 2 (SETTLE_CYCLES=1).
- Single request: req=8'h08 first sampled at edge 10 -> S=3 after edge 10; grant=8'h08, Output_bar=0 after edge 11. Drop req at edge 20 -> grant=0, Output_bar=1 after edge 20.
- Contention (MAX_HOLD=4, SETTLE=1): req=8'h22 held -> ch1 and ch5 alternate. Each grant lasts 4 cycles, separated by 2 cycles of Output_bar=1. grant is never 8'h22.
- Wrap and abort:
  - After ch7 releases with req=8'h41 -> ch0 is granted, not ch6.
  - Separately, dropping req[w] during SETTLE -> back to IDLE, no grant pulse, next winner chosen from the same pointer.
- Mid-operation reset: reset high during GRANT of ch4 -> next cycle grant=0, Output_bar=1, S=0, busy=0, pointer=7.
- FIXED_PRI0_EN: ch3 granted 1 cycle, req[0] rises -> ch3 released at that edge, ch0 granted 1+SETTLE_CYCLES edges later. ch0 held 20 cycles with req=8'hFF -> no preemption.
